// File: rtl/kf_bank_loader.sv
// kf_bank_loader: streams host words into the Data Bank write port and reads bank words back out over valid/ready.
// Optional KF_LOADER_CHECKSUM_EN adds csum, a mod-2**W sum of every word handshaken in the current burst.
module kf_bank_loader #(
    parameter int W     = 24,
    parameter int NR    = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_ld,
    input  logic             start_rd,
    input  logic [ADDRW-1:0] base,
    input  logic [ADDRW:0]   len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             busy,
    output logic             done,
    output logic             write,
    output logic [ADDRW-1:0] dira,
    output logic [W-1:0]     data,
    output logic [ADDRW-1:0] dirb,
`ifdef KF_LOADER_CHECKSUM_EN
    output logic [W-1:0]     csum,
`endif
    input  logic [W-1:0]     B
);
    typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, DONE} state_t;

    state_t           r_state;
    logic [ADDRW-1:0] r_addr;
    logic [ADDRW-1:0] r_dirb;
    logic [ADDRW:0]   r_rem;
    logic [W-1:0]     r_out_data;
    logic             r_out_valid;
    logic             w_start;
    logic             w_ld_hs;
    logic             w_rd_cap;
    logic             w_last;
    logic [ADDRW-1:0] w_addr_nx;
    logic [ADDRW-1:0] w_dirb;

    assign w_start   = r_state == IDLE && (start_ld || start_rd);
    assign w_ld_hs   = r_state == LOAD && in_valid;
    assign w_rd_cap  = r_state == READ && (!r_out_valid || out_ready);
    assign w_last    = r_rem == (ADDRW+1)'(1);
    assign w_addr_nx = (r_addr == ADDRW'(NR - 1)) ? '0 : r_addr + 1'b1;
    // Port B address follows the burst pointer in READ and freezes on the last word read otherwise.
    assign w_dirb    = r_state == READ ? r_addr : r_dirb;

    assign in_ready  = r_state == LOAD;
    assign write     = w_ld_hs;
    assign dira      = r_addr;
    assign data      = r_state == LOAD ? in_data : '0;
    assign dirb      = w_dirb;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_rem       <= '0;
            r_dirb      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_dirb <= w_dirb;
            case (r_state)
                IDLE: if (w_start) begin
                    r_addr  <= base;
                    r_rem   <= len;
                    r_state <= len == '0 ? DONE : start_ld ? LOAD : READ;
                end
                LOAD: if (w_ld_hs) begin
                    r_addr  <= w_addr_nx;
                    r_rem   <= r_rem - 1'b1;
                    r_state <= w_last ? DONE : LOAD;
                end
                READ: if (w_rd_cap) begin
                    r_out_data  <= B;
                    r_out_valid <= 1'b1;
                    r_addr      <= w_addr_nx;
                    r_rem       <= r_rem - 1'b1;
                    r_state     <= w_last ? DRAIN : READ;
                end
                DRAIN: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef KF_LOADER_CHECKSUM_EN
    logic [W-1:0] r_csum;

    assign csum = r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_csum <= '0;
        else if (w_start)
            r_csum <= '0;
        else if (w_ld_hs)
            r_csum <= r_csum + in_data;
        else if (w_rd_cap)
            r_csum <= r_csum + B;
    end
`endif
endmodule

// File: tb/tb_kf_bank_loader.sv
// tb_kf_bank_loader: burst table plus randomized bursts against a reference bank image; the bench also models the Data Bank.
module tb_kf_bank_loader;
    logic        clk;
    logic        rst_n;
    logic        start_ld;
    logic        start_rd;
    logic [4:0]  base;
    logic [5:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        busy;
    logic        done;
    logic        write;
    logic [4:0]  dira;
    logic [23:0] data;
    logic [4:0]  dirb;
    logic [23:0] B;
`ifdef KF_LOADER_CHECKSUM_EN
    logic [23:0] csum;
`endif

    int vecs = 0;
    int errs = 0;

    logic [23:0] mem     [32] = '{default: '0};
    logic [23:0] ref_mem [32] = '{default: '0};

    kf_bank_loader dut (
        .clk(clk), .rst_n(rst_n), .start_ld(start_ld), .start_rd(start_rd),
        .base(base), .len(len), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done), .write(write),
        .dira(dira), .data(data), .dirb(dirb),
`ifdef KF_LOADER_CHECKSUM_EN
        .csum(csum),
`endif
        .B(B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (write) mem[dira] <= data;
    assign B = mem[dirb];

    typedef struct {
        bit          ld;
        bit          both;
        logic [4:0]  base;
        logic [5:0]  len;
        int          wmode;
        bit   [31:0] vpat;
        bit   [31:0] rpat;
        int          plen;
        int          pct;
        int          exp_cyc;
    } burst_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] wgen(input int m, input int i);
        logic [23:0] r;
        case (m)
            1:       r = {8'hA5, i[7:0], 8'h5A};
            2:       r = 24'h111111 * 24'(i + 1);
            3:       r = i == 0 ? 24'h000001 : i == 1 ? 24'hFFFFFF : 24'h000010;
            default: r = 24'($urandom);
        endcase
        return r;
    endfunction

    task automatic run(input burst_t b);
        int cyc, k, n, done_cyc, bound, ai;
        bit ld, gv, gr, ei, pstall;
        logic [23:0] w, pdata, rsum;
        ld = b.ld || b.both;
        @(negedge clk);
        start_ld = ld;
        start_rd = b.both || !b.ld;
        base     = b.base;
        len      = b.len;
        cyc = 0; k = 0; n = 0; pstall = 0; pdata = '0; rsum = '0;
        done_cyc = b.len == 0 ? 1 : 1 << 30;
        bound    = 50 * int'(b.len) + 50;
        while (cyc < done_cyc && cyc < bound) begin
            @(negedge clk);
            cyc++;
            start_ld = 1'b0;
            start_rd = 1'b0;
            base     = 5'($urandom);
            len      = 6'($urandom);
            gv = b.plen > 0 ? b.vpat[(cyc - 1) % b.plen] : ($urandom_range(99) < b.pct);
            gr = b.plen > 0 ? b.rpat[(cyc - 1) % b.plen] : ($urandom_range(99) < b.pct);
            w  = wgen(b.wmode, k);
            in_valid  = gv;
            in_data   = gv ? w : 24'($urandom);
            out_ready = gr;
            #1;
            ei = ld && k < int'(b.len);
            chk("in_ready", in_ready, ei);
            chk("write", write, ei && gv);
            if (ei && gv) begin
                ai = (int'(b.base) + k) % 32;
                chk("dira", dira, ai);
                chk("data", data, w);
                ref_mem[ai] = w;
                rsum += w;
                k++;
                if (k == int'(b.len)) done_cyc = cyc + 1;
            end
            if (!ld) begin
                if (pstall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, pdata);
                end
                if (n == int'(b.len)) chk("extra_valid", out_valid, 0);
                if (out_valid && out_ready && n < int'(b.len)) begin
                    ai = (int'(b.base) + n) % 32;
                    chk("out_data", out_data, ref_mem[ai]);
                    rsum += ref_mem[ai];
                    n++;
                    if (n == int'(b.len)) done_cyc = cyc + 1;
                end
                pstall = out_valid && !out_ready;
                pdata  = out_data;
            end else
                chk("load_out_valid", out_valid, 0);
            chk("done", done, cyc == done_cyc);
            chk("busy", busy, 1);
        end
        chk("done_reached", cyc, done_cyc);
        if (b.exp_cyc >= 0) chk("latency", done_cyc, b.exp_cyc);
`ifdef KF_LOADER_CHECKSUM_EN
        chk("csum", csum, rsum);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_write", write, 0);
        chk("idle_done", done, 0);
    endtask

    burst_t tbl[11];
    burst_t rb;

    initial begin
        rst_n = 1'b0; start_ld = 0; start_rd = 0; base = 0; len = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        tbl[0]  = '{1, 0, 5'd0,  6'd32, 1, 0, 0, 0, 100, 33};
        tbl[1]  = '{0, 0, 5'd0,  6'd32, 0, 0, 0, 0, 100, 34};
        tbl[2]  = '{1, 0, 5'd30, 6'd4,  2, 0, 0, 0, 100, 5};
        tbl[3]  = '{0, 0, 5'd30, 6'd4,  0, 0, 0, 0, 100, 6};
        tbl[4]  = '{0, 0, 5'd0,  6'd3,  0, 0, 32'b101001, 6, 0, 8};
        tbl[5]  = '{1, 0, 5'd3,  6'd4,  0, 32'b101101, 0, 6, 0, 7};
        tbl[6]  = '{1, 0, 5'd9,  6'd0,  0, 0, 0, 0, 100, 1};
        tbl[7]  = '{0, 0, 5'd9,  6'd0,  0, 0, 0, 0, 100, 1};
        tbl[8]  = '{1, 1, 5'd12, 6'd3,  0, 0, 0, 0, 100, 4};
        tbl[9]  = '{0, 0, 5'd12, 6'd3,  0, 0, 0, 0, 100, 5};
        tbl[10] = '{1, 0, 5'd20, 6'd3,  3, 0, 0, 0, 100, 4};
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_write", write, 0);
        chk("rst_dira", dira, 0);
        chk("rst_dirb", dirb, 0);
        chk("rst_data", data, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            run(tbl[i]);
`ifdef KF_LOADER_CHECKSUM_EN
            if (i == 10) chk("csum_wrap", csum, 24'h000010);
`endif
        end
        for (int i = 0; i < 24; i++) begin
            rb = '{1'($urandom_range(1)), 0, 5'($urandom), 6'($urandom_range(32)),
                   0, 0, 0, 0, int'($urandom_range(30, 100)), -1};
            run(rb);
        end
        // Reset lands while a load is mid-burst: two of five words already written.
        @(negedge clk);
        start_ld = 1; base = 5'd5; len = 6'd5;
        @(negedge clk);
        start_ld = 0; in_valid = 1; in_data = 24'hABC001;
        @(negedge clk);
        in_data = 24'hABC002;
        @(negedge clk);
        in_data = 24'hABC003;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write", write, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_dira", dira, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_dirb", dirb, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        ref_mem[5] = 24'hABC001;
        ref_mem[6] = 24'hABC002;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        run('{0, 0, 5'd5, 6'd5, 0, 0, 0, 0, 100, 7});
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
